// File: rtl/router_pkt_tx_pkg.sv
// Shared constants, state encoding and header helpers for the router packet transmitter.
package router_pkg;
   localparam int DATA_W       = 8;
   localparam int ADDR_W       = 2;
   localparam int LEN_W        = DATA_W - ADDR_W;
   localparam int DEPTH        = 1 << LEN_W;
   localparam int MAX_DEST     = 2;
   localparam int HDR_DEST_LSB = 0;
   localparam int HDR_LEN_LSB  = ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_HEADER,
      S_PAYLOAD,
      S_PARITY
   } state_e;

   // Header byte: len in [7:2], dest in [1:0].
   function automatic logic [DATA_W-1:0] mk_header(input logic [LEN_W-1:0] l,
                                                   input logic [ADDR_W-1:0] d);
      return {l, d};
   endfunction
endpackage

// File: rtl/router_pkt_tx_if.sv
// Request, upstream payload and router-side signals of the packet transmitter.
// inject_err exists only when ROUTER_TX_ERR_INJ_EN is defined.
interface router_pkt_tx_if;
   import router_pkg::*;

   logic                start;
   logic [ADDR_W-1:0]   dest;
   logic [LEN_W-1:0]    len;
   logic                tx_ready;
   logic                req_err;
   logic [DATA_W-1:0]   pl_data;
   logic                pl_valid;
   logic                pl_ready;
   logic                busy;
   logic [DATA_W-1:0]   data_in;
   logic                pkt_valid;
   logic                done;
`ifdef ROUTER_TX_ERR_INJ_EN
   logic                inject_err;

   modport master (input  start, dest, len, inject_err, pl_data, pl_valid, busy,
                   output tx_ready, req_err, pl_ready, data_in, pkt_valid, done);
   modport slave  (output start, dest, len, inject_err, pl_data, pl_valid, busy,
                   input  tx_ready, req_err, pl_ready, data_in, pkt_valid, done);
`else
   modport master (input  start, dest, len, pl_data, pl_valid, busy,
                   output tx_ready, req_err, pl_ready, data_in, pkt_valid, done);
   modport slave  (output start, dest, len, pl_data, pl_valid, busy,
                   input  tx_ready, req_err, pl_ready, data_in, pkt_valid, done);
`endif
endinterface

// File: rtl/router_pkt_tx_buf.sv
// Payload staging buffer: one write port used while filling, one asynchronous read port used while sending.
module router_tx_buf
   import router_pkg::*;
(
   input  logic              clock,
   input  logic              we,
   input  logic [LEN_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [LEN_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clock) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];
endmodule

// File: rtl/router_pkt_tx.sv
// Router packet transmitter: stages len payload bytes, then sends header, payload and parity under busy.
// Optional ROUTER_TX_ERR_INJ_EN adds inject_err, which flips bit 0 of the sent parity byte.
module router_pkt_tx
   import router_pkg::*;
(
   input  logic           clock,
   input  logic           resetn,
   router_pkt_tx_if.master tx
);
   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   dest_q, dest_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [LEN_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [LEN_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0]   parity_q, parity_d;
   logic [DATA_W-1:0]   data_in_q, data_in_d;
   logic                pkt_valid_q, pkt_valid_d;
   logic                tx_ready_q, tx_ready_d;
   logic                req_err_q, req_err_d;
   logic                pl_ready_q, pl_ready_d;
   logic                done_q, done_d;
   logic                inj_q, inj_d;
   logic                buf_we;
   logic [DATA_W-1:0]   buf_rdata;

   assign buf_we = pl_ready_q && tx.pl_valid;

   router_tx_buf u_buf (
      .clock (clock),
      .we    (buf_we),
      .waddr (wr_ptr_q),
      .wdata (tx.pl_data),
      .raddr (rd_ptr_q),
      .rdata (buf_rdata)
   );

   always_comb begin
      state_d     = state_q;
      dest_d      = dest_q;
      len_d       = len_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      parity_d    = parity_q;
      data_in_d   = data_in_q;
      pkt_valid_d = pkt_valid_q;
      inj_d       = inj_q;
      req_err_d   = 1'b0;
      done_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (tx.start) begin
               if (tx.dest <= ADDR_W'(MAX_DEST) && tx.len != '0) begin
                  dest_d   = tx.dest;
                  len_d    = tx.len;
                  parity_d = '0;
                  wr_ptr_d = '0;
                  rd_ptr_d = '0;
`ifdef ROUTER_TX_ERR_INJ_EN
                  inj_d    = tx.inject_err;
`else
                  inj_d    = 1'b0;
`endif
                  state_d  = S_FILL;
               end else begin
                  req_err_d = 1'b1;
               end
            end
         end
         S_FILL: begin
            if (buf_we) begin
               wr_ptr_d = wr_ptr_q + LEN_W'(1);
               if (wr_ptr_q == len_q - LEN_W'(1)) begin
                  data_in_d   = mk_header(len_q, dest_q);
                  parity_d    = mk_header(len_q, dest_q);
                  pkt_valid_d = 1'b1;
                  state_d     = S_HEADER;
               end
            end
         end
         S_HEADER: begin
            if (!tx.busy) begin
               data_in_d = buf_rdata;
               rd_ptr_d  = rd_ptr_q + LEN_W'(1);
               state_d   = S_PAYLOAD;
            end
         end
         S_PAYLOAD: begin
            // rd_ptr counts bytes already loaded onto data_in; equal to len means the last one is leaving.
            if (!tx.busy) begin
               parity_d = parity_q ^ data_in_q;
               if (rd_ptr_q == len_q) begin
                  data_in_d   = parity_d ^ {{(DATA_W-1){1'b0}}, inj_q};
                  pkt_valid_d = 1'b0;
                  state_d     = S_PARITY;
               end else begin
                  data_in_d = buf_rdata;
                  rd_ptr_d  = rd_ptr_q + LEN_W'(1);
               end
            end
         end
         S_PARITY: begin
            if (!tx.busy) begin
               data_in_d = '0;
               done_d    = 1'b1;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      tx_ready_d = (state_d == S_IDLE);
      pl_ready_d = (state_d == S_FILL);
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         dest_q      <= '0;
         len_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         parity_q    <= '0;
         data_in_q   <= '0;
         pkt_valid_q <= 1'b0;
         tx_ready_q  <= 1'b0;
         req_err_q   <= 1'b0;
         pl_ready_q  <= 1'b0;
         done_q      <= 1'b0;
         inj_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         dest_q      <= dest_d;
         len_q       <= len_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         parity_q    <= parity_d;
         data_in_q   <= data_in_d;
         pkt_valid_q <= pkt_valid_d;
         tx_ready_q  <= tx_ready_d;
         req_err_q   <= req_err_d;
         pl_ready_q  <= pl_ready_d;
         done_q      <= done_d;
         inj_q       <= inj_d;
      end
   end

   assign tx.data_in   = data_in_q;
   assign tx.pkt_valid = pkt_valid_q;
   assign tx.tx_ready  = tx_ready_q;
   assign tx.req_err   = req_err_q;
   assign tx.pl_ready  = pl_ready_q;
   assign tx.done      = done_q;
endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: vector table, hand-written corner sequences and random packets
// checked against a byte-list model (header, payload, XOR parity).
module tb_router_pkt_tx;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [7:0] pl [64];

   router_pkt_tx_if bus ();

   router_pkt_tx dut (
      .clock  (clk),
      .resetn (resetn),
      .tx     (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  dest;
      logic [5:0]  len;
      logic [23:0] pbytes;
      logic [15:0] bmask;
      logic [7:0]  ehdr;
      logic [7:0]  epar;
      bit          eerr;
   } vec_t;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req_fill(input logic [1:0] d, input int l, input logic inj, input bit rnd);
      int   n, cyc;
      logic rdy;
      bus.start = 1'b1;
      bus.dest  = d;
      bus.len   = l[5:0];
`ifdef ROUTER_TX_ERR_INJ_EN
      bus.inject_err = inj;
`endif
      tick();
      bus.start = 1'b0;
      check("pl_ready_after_start", bus.pl_ready, 1);
      check("tx_ready_low_in_fill", bus.tx_ready, 0);
      n = 0;
      cyc = 0;
      while (n < l && cyc < 1000) begin
         bus.pl_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         bus.pl_data  = pl[n];
         rdy = bus.pl_ready;
         tick();
         if (bus.pl_valid && rdy) n++;
         cyc++;
      end
      bus.pl_valid = 1'b0;
      check("fill_timeout", cyc < 1000, 1);
      check("pl_ready_drop", bus.pl_ready, 0);
      check("hdr_valid_timing", bus.pkt_valid, 1);
   endtask

   task automatic transmit(input int l, input logic [63:0] bmask, input bit rnd,
                           input logic [7:0] ehdr, input logic [7:0] epar);
      logic [7:0] got [$];
      logic [7:0] pd;
      logic       pv, b;
      int         cyc;
      got = {};
      cyc = 0;
      while (got.size() < l + 2 && cyc < 2000) begin
         pd = bus.data_in;
         pv = bus.pkt_valid;
         b  = rnd ? ($urandom_range(0, 3) == 0) : bmask[cyc % 64];
         bus.busy = b;
         tick();
         cyc++;
         if (!b) begin
            check("pkt_valid_phase", pv, (got.size() <= l) ? 1 : 0);
            got.push_back(pd);
         end else begin
            check("hold_data", bus.data_in, pd);
            check("hold_valid", bus.pkt_valid, pv);
         end
      end
      bus.busy = 1'b0;
      check("tx_timeout", cyc < 2000, 1);
      if (got.size() == l + 2) begin
         check("header", got[0], ehdr);
         for (int i = 0; i < l; i++) check("payload", got[i+1], pl[i]);
         check("parity", got[l+1], epar);
      end
      check("done_pulse", bus.done, 1);
      check("tx_ready_back", bus.tx_ready, 1);
      check("idle_data", bus.data_in, 0);
      check("idle_valid", bus.pkt_valid, 0);
      tick();
      check("done_single", bus.done, 0);
   endtask

   task automatic run_err(input logic [1:0] d, input logic [5:0] l);
      bus.start = 1'b1;
      bus.dest  = d;
      bus.len   = l;
      tick();
      bus.start = 1'b0;
      check("req_err_pulse", bus.req_err, 1);
      check("req_err_pl_ready", bus.pl_ready, 0);
      check("req_err_tx_ready", bus.tx_ready, 1);
      tick();
      check("req_err_single", bus.req_err, 0);
      check("req_err_valid", bus.pkt_valid, 0);
      check("req_err_pl_ready2", bus.pl_ready, 0);
   endtask

   function automatic logic [7:0] model_par(input logic [1:0] d, input int l, input logic inj);
      logic [7:0] p;
      p = 8'((l << 2) | d);
      for (int i = 0; i < l; i++) p = p ^ pl[i];
      return p ^ {7'd0, inj};
   endfunction

   initial begin
      vec_t vecs [6];
      vecs[0] = '{2'd0, 6'd3, 24'h112233, 16'h0000, 8'h0C, 8'h0C, 1'b0};
      vecs[1] = '{2'd1, 6'd3, 24'h112233, 16'h001A, 8'h0D, 8'h0D, 1'b0};
      vecs[2] = '{2'd3, 6'd5, 24'h000000, 16'h0000, 8'h00, 8'h00, 1'b1};
      vecs[3] = '{2'd1, 6'd0, 24'h000000, 16'h0000, 8'h00, 8'h00, 1'b1};
      vecs[4] = '{2'd2, 6'd1, 24'hA50000, 16'h0005, 8'h06, 8'hA3, 1'b0};
      vecs[5] = '{2'd2, 6'd2, 24'hFF0F00, 16'h0003, 8'h0A, 8'hFA, 1'b0};

      bus.start = 1'b0; bus.dest = '0; bus.len = '0;
      bus.pl_data = '0; bus.pl_valid = 1'b0; bus.busy = 1'b0;
`ifdef ROUTER_TX_ERR_INJ_EN
      bus.inject_err = 1'b0;
`endif

      // reset held for two edges
      for (int i = 0; i < 2; i++) begin
         tick();
         check("rst_data_in", bus.data_in, 0);
         check("rst_pkt_valid", bus.pkt_valid, 0);
         check("rst_tx_ready", bus.tx_ready, 0);
         check("rst_pl_ready", bus.pl_ready, 0);
         check("rst_done", bus.done, 0);
         check("rst_req_err", bus.req_err, 0);
      end
      resetn = 1'b1;
      tick();
      check("tx_ready_after_rst", bus.tx_ready, 1);

      for (int v = 0; v < 6; v++) begin
         if (vecs[v].eerr) begin
            run_err(vecs[v].dest, vecs[v].len);
         end else begin
            pl[0] = vecs[v].pbytes[23:16];
            pl[1] = vecs[v].pbytes[15:8];
            pl[2] = vecs[v].pbytes[7:0];
            req_fill(vecs[v].dest, int'(vecs[v].len), 1'b0, 1'b0);
            transmit(int'(vecs[v].len), 64'(vecs[v].bmask), 1'b0, vecs[v].ehdr, vecs[v].epar);
         end
      end

      // full-depth packet: payload 0..62
      for (int i = 0; i < 63; i++) pl[i] = 8'(i);
      req_fill(2'd0, 63, 1'b0, 1'b0);
      transmit(63, 64'd0, 1'b0, 8'hFC, model_par(2'd0, 63, 1'b0));

      // second packet abandoned by reset while payload byte 10 is on the line
      for (int i = 0; i < 20; i++) pl[i] = 8'(8'h40 + i);
      req_fill(2'd2, 20, 1'b0, 1'b0);
      bus.busy = 1'b0;
      for (int i = 0; i < 11; i++) begin
         bus.start = (i == 5);
         bus.dest  = 2'd3;
         bus.len   = 6'd0;
         tick();
         if (i == 5) check("start_ignored_busy", bus.req_err, 0);
      end
      bus.start = 1'b0;
      check("pre_reset_byte10", bus.data_in, pl[10]);
      resetn = 1'b0;
      tick();
      check("midpkt_rst_valid", bus.pkt_valid, 0);
      check("midpkt_rst_data", bus.data_in, 0);
      check("midpkt_rst_tx_ready", bus.tx_ready, 0);
      resetn = 1'b1;
      tick();
      check("post_rst_tx_ready", bus.tx_ready, 1);

`ifdef ROUTER_TX_ERR_INJ_EN
      pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
      req_fill(2'd0, 3, 1'b1, 1'b0);
      transmit(3, 64'd0, 1'b0, 8'h0C, 8'h0D);
      bus.inject_err = 1'b0;
`endif

      // random packets against the byte-list model
      for (int k = 0; k < 20; k++) begin
         logic [1:0] d;
         int         l;
         d = 2'($urandom_range(0, 2));
         l = (k == 7) ? 63 : int'($urandom_range(1, 24));
         for (int i = 0; i < l; i++) pl[i] = 8'($urandom);
         req_fill(d, l, 1'b0, 1'b1);
         transmit(l, 64'd0, 1'b1, 8'((l << 2) | d), model_par(d, l, 1'b0));
         if ($urandom_range(0, 2) == 0) tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/router_pkt_tx.md
# router_pkt_tx

Packet transmitter that drives the router's input side: data_in, pkt_valid and busy. It accepts a packet request (destination, length), stages the payload bytes from an upstream byte stream, and then sends header, payload and parity. It obeys the router's busy back-pressure so that no byte is skipped or duplicated. It sits between a traffic source (or test harness) and the router top.

## Interface
- DATA_W, 8, byte width. Fixed at 8; the header format depends on it.
- ADDR_W, 2, destination field width. Destinations 0..2 are valid.
- LEN_W (localparam), DATA_W-ADDR_W = 6. Payload length is 1..63; the staging buffer depth is 2**LEN_W.

Ports:
- clock  in  1  single clock; all logic on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  packet request, qualified by tx_ready.
- dest  in  2  destination port, sampled with start.
- len  in  6  payload byte count, sampled with start.
- tx_ready  out  1  high in IDLE, ready to accept start.
- req_err  out  1  one-cycle pulse when a request is rejected.
- pl_data  in  8  upstream payload byte.
- pl_valid  in  1  upstream byte valid.
- pl_ready  out  1  high in FILL; a byte transfers when pl_valid && pl_ready.
- busy  in  1  router back-pressure.
- data_in  out  8  byte to the router.
- pkt_valid  out  1  high during header and payload; low during parity.
- done  out  1  one-cycle pulse after the parity byte is accepted.

## Operation
- States: IDLE, FILL, HEADER, PAYLOAD, PARITY.
- IDLE:
  - start with dest<=2 and len>=1: capture dest/len, clear parity accumulator and buffer pointers, go to FILL.
  - start with dest==3 or len==0: pulse req_err, stay in IDLE.
- FILL:
  - pl_ready=1; each transfer writes the buffer at wr_ptr and increments it.
  - After the len-th transfer, pl_ready drops and the state goes to HEADER.
- HEADER: data_in={len,dest}, pkt_valid=1, parity=header.
- PAYLOAD:
  - data_in=buf[rd_ptr], pkt_valid=1.
  - Each advance XORs the byte into parity and increments rd_ptr.
  - Leaves after len bytes.
- PARITY: data_in=parity (XOR of header and all payload bytes), pkt_valid=0.
- Advance rule: a byte is accepted at a rising edge where busy==0. While busy==1, data_in and pkt_valid hold exactly.
- After the parity byte is accepted: pulse done, return to IDLE with data_in=0 and pkt_valid=0.
- start outside IDLE is ignored and does not raise req_err.
- Buffer boundaries:
  - len=63 fills the buffer to 63 of 64 entries.
  - Pointers are LEN_W bits and never wrap within a packet; both reset to 0 per packet.

## Timing
- All outputs are registered.
- Reset values (resetn low at an edge): data_in=0, pkt_valid=0, tx_ready=0, req_err=0, pl_ready=0, done=0; state IDLE.
- tx_ready is 1 from the first edge with resetn=1.
- start accepted at edge N: pl_ready=1 from N+1.
- Last fill transfer at edge M: header on data_in/pkt_valid from M+1.
- With busy=0 throughout, one byte per cycle: header, len payload bytes, parity.
- Total line occupancy is len+2 cycles.
- done is high in the cycle after parity acceptance, coincident with tx_ready returning to 1.
- busy may rise at any edge, including in the cycle after the header (the router's first-data state); the held byte is re-presented until accepted.
- resetn low mid-packet: the next edge forces the reset values and IDLE; the partial packet is abandoned.
- A pl_valid transfer and busy in the same cycle cannot conflict, because FILL and transmit are separate states.

## Configuration
- ROUTER_TX_ERR_INJ_EN defined:
  - Adds input port inject_err, sampled with start.
  - When it was 1, the transmitted parity byte has bit 0 inverted.
  - The header, payload and internal accumulator are unchanged.
- ROUTER_TX_ERR_INJ_EN undefined: the port is absent and parity is always correct.

## Structure
- Shared package router_pkg:
  - state enum;
  - DATA_W, ADDR_W, LEN_W constants;
  - header field positions (len [7:2], dest [1:0]);
  - MAX_DEST=2.
- Sub-module router_tx_buf: 64x8 register array with write port (FILL) and read port (PAYLOAD), pointers in the parent.
- The FSM, parity accumulator and output registers live in router_pkt_tx.

## Test plan
- Reset: hold resetn=0 for 2 cycles, then release -> data_in=0, pkt_valid=0; tx_ready=1 one edge after release.
- dest=0, len=3, payload 0x11,0x22,0x33, busy=0:
  - data_in sequence 0x0C,0x11,0x22,0x33 with pkt_valid=1;
  - then 0x0C with pkt_valid=0;
  - done pulse, then idle.
- Same packet with dest=1, busy=1 for 1 cycle after header and 2 cycles on byte 0x22:
  - 0x0D header;
  - 0x11 held 2 cycles, 0x22 held 3 cycles;
  - parity 0x0D; no byte lost or duplicated.
- dest=3, len=5 and dest=1, len=0 -> req_err pulses once each; pl_ready and pkt_valid stay 0.
- len=63 with payload 0..62 -> 63 payload bytes in order, then correct parity; resetn=0 during payload byte 10 of a second packet -> pkt_valid=0, data_in=0 at the next edge.
- With ROUTER_TX_ERR_INJ_EN and inject_err=1 on the test-2 packet -> parity byte is 0x0D; all other bytes are unchanged.
